// File: rtl/y86_pkg.sv
// Shared Y86 pipeline definitions: status codes, memory-touching icodes and
// the data-memory responder state encoding.
package y86_pkg;

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        CLEAR = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage load/store handshake: request channel towards the data memory
// and response channel back to the memory stage.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// 64-bit word storage with one synchronous write port and one read port that
// is registered on the access edge; isolated so an SRAM macro can replace it.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic          rd_en,
    input  logic          rd_zero,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rd_zero forces the output word to 0 for write acks and errored reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_zero ? 64'd0 : mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Y86 data-memory responder: valid/ready slave with programmable latency and ADR flag.
// Optional build macro DMEM_CLEAR_ON_RESET_EN zeroes the array after every reset.
module dmem_responder
    import y86_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [63:0] MAX_ADDR = 64'(DEPTH - 1);

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam dmem_state_t RESET_STATE = CLEAR;
`else
    localparam dmem_state_t RESET_STATE = IDLE;
`endif

    dmem_state_t   state;
    dmem_state_t   state_next;
    logic [3:0]    cnt;
    logic          req_ready_q;
    logic          rsp_err_q;
    logic          lat_we;
    logic          lat_err;
    logic [AW-1:0] lat_addr;
    logic [63:0]   lat_wdata;
    logic          accept;
    logic          access;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [63:0]   mem_wdata;

`ifdef DMEM_CLEAR_ON_RESET_EN
    logic [AW-1:0] clr_addr;
    logic          clearing;

    assign clearing = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (clearing) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end
`endif

    assign accept = bus.req_valid && req_ready_q;
    assign access = (state == WAIT) && (cnt == 4'd0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = WAIT;
            WAIT: if (cnt == 4'd0) state_next = RESP;
            RESP: if (bus.rsp_ready) state_next = IDLE;
`ifdef DMEM_CLEAR_ON_RESET_EN
            CLEAR: if (clr_addr == AW'(DEPTH - 1)) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // req_ready is registered from the next state so it is low in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RESET_STATE;
            req_ready_q <= 1'b0;
            cnt         <= '0;
            rsp_err_q   <= 1'b0;
            lat_we      <= 1'b0;
            lat_err     <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
        end else begin
            state       <= state_next;
            req_ready_q <= (state_next == IDLE);
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_addr  <= bus.req_addr[AW-1:0];
                lat_wdata <= bus.req_wdata;
                lat_err   <= (bus.req_addr > MAX_ADDR);
                cnt       <= 4'(LATENCY - 1);
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_err_q <= lat_err;
            end
        end
    end

    // The rst gate keeps an access scheduled on a reset edge from committing.
    always_comb begin
        mem_we    = !rst && access && lat_we && !lat_err;
        mem_waddr = lat_addr;
        mem_wdata = lat_wdata;
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (clearing) begin
            mem_we    = !rst;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
`endif
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .rd_en   (access),
        .rd_zero (lat_we || lat_err),
        .raddr   (lat_addr),
        .rdata   (bus.rsp_rdata)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=256, LATENCY=2); also covers the
// DMEM_CLEAR_ON_RESET_EN build when that macro is defined.
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam int READY_DELAY = DEPTH;
`else
    localparam int READY_DELAY = 1;
`endif

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for req_ready, presents one request, returns on the negedge after acceptance.
    task automatic applyStimulus(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
        int guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) checkOutput("req_ready timeout", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic transact(input string tag, input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] exp_rdata,
                            input logic exp_err);
        int n = 1;
        applyStimulus(we, addr, wdata);
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " latency"}, 64'(n), 64'(LATENCY + 1));
        checkOutput({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
        checkOutput({tag, " err"}, 64'(bus.rsp_err), 64'(exp_err));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput({tag, " rsp_valid drop"}, 64'(bus.rsp_valid), 64'd0);
        checkOutput({tag, " req_ready rise"}, 64'(bus.req_ready), 64'd1);
    endtask

    task automatic doReset(input string tag);
        int n = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput({tag, " req_ready in reset"}, 64'(bus.req_ready), 64'd0);
        checkOutput({tag, " rsp_valid in reset"}, 64'(bus.rsp_valid), 64'd0);
        checkOutput({tag, " rsp_rdata in reset"}, bus.rsp_rdata, 64'd0);
        checkOutput({tag, " rsp_err in reset"}, 64'(bus.rsp_err), 64'd0);
        rst = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_ready !== 1'b1 && n < 1000);
        checkOutput({tag, " req_ready delay"}, 64'(n), 64'(READY_DELAY));
    endtask

    initial begin
        logic [63:0] held_rdata;
        logic        held_err;
        logic [7:0]  rv_seen;
        logic [7:0]  rr_seen;
        logic [63:0] rdata_first;
        logic [63:0] rdata_second;
        logic [63:0] exp_addr5;

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);

        doReset("init");

`ifdef DMEM_CLEAR_ON_RESET_EN
        transact("clear read 0xFF", 1'b0, 64'hFF, 64'h0, 64'h0, 1'b0);
`endif

        transact("write 0x10", 1'b1, 64'h10, 64'h1122334455667788, 64'h0, 1'b0);
        transact("read 0x10", 1'b0, 64'h10, 64'h0, 64'h1122334455667788, 1'b0);

        transact("write 0x2C", 1'b1, 64'h2C, 64'hAA, 64'h0, 1'b0);
        transact("read 256", 1'b0, 64'd256, 64'h0, 64'h0, 1'b1);
        transact("write 0x12C", 1'b1, 64'h12C, 64'hFF, 64'h0, 1'b1);
        transact("read high addr", 1'b0, 64'h8000_0000_0000_0010, 64'h0, 64'h0, 1'b1);
        transact("read 0x2C", 1'b0, 64'h2C, 64'h0, 64'hAA, 1'b0);

        // Backpressure: six RESP cycles, rsp_ready only in the last one.
        applyStimulus(1'b0, 64'h10, 64'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp rsp_valid first", 64'(bus.rsp_valid), 64'd1);
        checkOutput("bp rdata first", bus.rsp_rdata, 64'h1122334455667788);
        held_rdata = bus.rsp_rdata;
        held_err   = bus.rsp_err;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checkOutput("bp rsp_valid held", 64'(bus.rsp_valid), 64'd1);
            checkOutput("bp rdata held", bus.rsp_rdata, held_rdata);
            checkOutput("bp err held", 64'(bus.rsp_err), 64'(held_err));
            checkOutput("bp req_ready low", 64'(bus.req_ready), 64'd0);
            if (i == 5) bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput("bp rsp_valid after hs", 64'(bus.rsp_valid), 64'd0);
        checkOutput("bp req_ready after hs", 64'(bus.req_ready), 64'd1);

        // req_valid held high over two reads with rsp_ready tied high.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 64'h10;
        @(posedge clk);
        rv_seen      = '0;
        rr_seen      = '0;
        rdata_first  = '0;
        rdata_second = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            rv_seen[n-1] = bus.rsp_valid;
            rr_seen[n-1] = bus.req_ready;
            if (n == 1) bus.req_addr = 64'h2C;
            if (n == 3) rdata_first = bus.rsp_rdata;
            if (n == 5) bus.req_valid = 1'b0;
            if (n == 7) rdata_second = bus.rsp_rdata;
        end
        bus.rsp_ready = 1'b0;
        checkOutput("b2b rsp_valid pattern", 64'(rv_seen), 64'h44);
        checkOutput("b2b req_ready pattern", 64'(rr_seen), 64'h88);
        checkOutput("b2b first rdata", rdata_first, 64'h1122334455667788);
        checkOutput("b2b second rdata", rdata_second, 64'hAA);

        // Reset asserted on the edge where the pending write would commit.
        transact("write addr5", 1'b1, 64'h5, 64'h7, 64'h0, 1'b0);
        applyStimulus(1'b1, 64'h5, 64'h99);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midwait rsp_valid in reset", 64'(bus.rsp_valid), 64'd0);
        checkOutput("midwait req_ready in reset", 64'(bus.req_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midwait rsp_valid after reset", 64'(bus.rsp_valid), 64'd0);
`ifdef DMEM_CLEAR_ON_RESET_EN
        exp_addr5 = 64'h0;
`else
        exp_addr5 = 64'h7;
`endif
        transact("read addr5", 1'b0, 64'h5, 64'h0, exp_addr5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
